// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-port configuration SPI flash arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN, GUARD} arb_state_t;

    localparam int PORT_JTAG = 0;
    localparam int PORT_USER = 1;

    localparam logic PIN_CSN_IDLE = 1'b1;
    localparam logic PIN_SCK_IDLE = 1'b0;
    localparam logic PIN_SDI_IDLE = 1'b0;

    localparam int GUARD_W = 8;
    localparam int IDLE_W  = 16;

endpackage

// File: rtl/spi_arb_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module spi_arb_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter handing the configuration SPI flash to the JTAG bridge
// or the user SPI master, with a chip-select guard gap and idle-owner revocation.
module spi_flash_arbiter
    import spi_arb_pkg::*;
#(
    parameter int CS_GUARD_CYCLES = 4,
    parameter int IDLE_TIMEOUT    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic [1:0] m_csn,
    input  logic [1:0] m_sck,
    input  logic [1:0] m_mosi,
    output logic [1:0] m_miso,
    output logic       csn,
    output logic       sck,
    output logic       sdi_dq0,
    input  logic       sdo_dq1,
    output logic       wpn_dq2,
    output logic       hldn_dq3,
    output logic       busy,
    output logic       timeout_evt
);

    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(CS_GUARD_CYCLES - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LOAD  =
        (IDLE_TIMEOUT == 0) ? '0 : IDLE_W'(IDLE_TIMEOUT - 1);

    arb_state_t state;
    logic       owner;
    logic       last_owner;
    logic       own_req, own_csn, idle_cyc, revoke, pick;
    logic       guard_done, idle_done;

    assign own_req  = req[owner];
    assign own_csn  = m_csn[owner];
    assign idle_cyc = (state == OWN) && own_req && own_csn;
    assign revoke   = idle_cyc && idle_done && (IDLE_TIMEOUT != 0);
    // On a tie the port that did not own the flash last goes first.
    assign pick     = (req == 2'b11) ? ~last_owner : req[PORT_USER];

    // Guard counter is preloaded the whole time it is not counting the gap.
    spi_arb_timer #(.W(GUARD_W)) u_guard (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state != GUARD),
        .en       (state == GUARD),
        .load_val (GUARD_LOAD),
        .done     (guard_done)
    );

    // Idle counter restarts whenever the owner has chip select low.
    spi_arb_timer #(.W(IDLE_W)) u_idle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     ((state != OWN) || !own_csn),
        .en       (idle_cyc),
        .load_val (IDLE_LOAD),
        .done     (idle_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_owner  <= 1'b1;
            gnt         <= 2'b00;
            csn         <= PIN_CSN_IDLE;
            sck         <= PIN_SCK_IDLE;
            sdi_dq0     <= PIN_SDI_IDLE;
            busy        <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        state <= OWN;
                        owner <= pick;
                        gnt   <= pick ? 2'b10 : 2'b01;
                        busy  <= 1'b1;
                    end
                end
                OWN: begin
                    if (!own_req || revoke) begin
                        // Release or revocation: park the pins on this same edge.
                        state       <= GUARD;
                        last_owner  <= owner;
                        gnt         <= 2'b00;
                        csn         <= PIN_CSN_IDLE;
                        sck         <= PIN_SCK_IDLE;
                        sdi_dq0     <= PIN_SDI_IDLE;
                        timeout_evt <= own_req;
                    end else begin
                        csn     <= own_csn;
                        sck     <= m_sck[owner];
                        sdi_dq0 <= m_mosi[owner];
                    end
                end
                GUARD: begin
                    if (guard_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_miso   = gnt & {2{sdo_dq1}};
    assign wpn_dq2  = 1'b1;
    assign hldn_dq3 = 1'b1;

endmodule
